// File: rtl/zero_responder.sv
// zero_responder: stub slave endpoint that answers every request with a
// constant response after a minimum latency, keeping requests in order.
module zero_responder #(
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int DEPTH = 2,
  parameter int LATENCY = 1,
  parameter logic [DATA_W-1:0] CONST = '0,
  parameter bit DENY = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  input  logic              req_read,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_error,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [AGE_W-1:0] RIPE = AGE_W'(LATENCY);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [ID_W-1:0]  id_q [DEPTH];
  logic [ID_W-1:0]  id_d [DEPTH];
  logic [DEPTH-1:0] rd_q, rd_d;
  logic [AGE_W-1:0] age_q [DEPTH];
  logic [AGE_W-1:0] age_d [DEPTH];

  logic push;
  logic pop;

  // req_ready looks only at registered count, never at resp_ready
  always_comb begin
    req_ready  = !reset && (count_q < FULL);
    busy       = (count_q != '0);
    resp_valid = busy && (age_q[rptr_q] >= RIPE);
    push       = req_valid && req_ready;
    pop        = resp_valid && resp_ready;
    resp_id    = '0;
    resp_data  = '0;
    resp_error = 1'b0;
    if (resp_valid) begin
      resp_id    = id_q[rptr_q];
      resp_data  = rd_q[rptr_q] ? CONST : '0;
      resp_error = DENY;
    end
  end

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    id_d    = id_q;
    rd_d    = rd_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = (age_q[i] < RIPE) ? age_q[i] + 1'b1 : age_q[i];
    end
    if (push) begin
      id_d[wptr_q]  = req_id;
      rd_d[wptr_q]  = req_read;
      age_d[wptr_q] = AGE_W'(1);
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]  <= '0;
        age_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rd_q    <= rd_d;
      id_q    <= id_d;
      age_q   <= age_d;
    end
  end

endmodule
